mul_mem_seq_ctrl: RTL and testbench

- Parametrised successor to the single-shot multiplier/memory control FSM.
- Sequences a batch of N multiply operations. Each operation: load operand A and operand B from the register file, wait a programmable multiplier latency, write the product to RAM, read it back.
- Sits between the top-level start/done interface and the register file, multiplier and RAM datapath.
- Adds a start/busy/done handshake, auto-incrementing addresses, a batch counter and a multi-cycle multiply wait.

---
 rtl/mul_mem_seq_ctrl_pkg.sv | 36 +++
 rtl/mul_mem_seq_ctrl_if.sv | 58 +++++
 rtl/mul_mem_seq_ctrl_mul_lat_counter.sv | 30 +++
 rtl/mul_mem_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mul_mem_seq_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mul_mem_seq_ctrl_pkg.sv
// mul_mem_pkg: shared definitions for the multiplier/memory batch sequencer.
// Holds the 3-bit state encoding (also consumed by the seven-segment status
// display) and the DA/SA/SB control bundle with its decode helper.
// Optional feature macro used elsewhere in this slice: MUL_MEM_READBACK_CHECK_EN.
package mul_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD_A = 3'b001,
    LOAD_B = 3'b010,
    MUL    = 3'b011,
    WRITE  = 3'b100,
    READ   = 3'b101,
    DONE   = 3'b110
  } state_t;

  // Field order is fixed: DA, SA, SB (MSB to LSB).
  typedef struct packed {
    logic da;
    logic sa;
    logic sb;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD_A:           c = '{da: 1'b0, sa: 1'b0, sb: 1'b1};
      LOAD_B:           c = '{da: 1'b1, sa: 1'b1, sb: 1'b0};
      MUL, WRITE, READ: c = '{da: 1'b0, sa: 1'b1, sb: 1'b0};
      default:          c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_mem_seq_ctrl_if.sv
// mul_mem_seq_ctrl_if: start/done handshake plus register-file and RAM
// control bus of the batch sequencer.
//   master : the sequencer (receives start/addresses/op_count, drives strobes,
//            addresses, st_out, busy, done)
//   slave  : the surrounding datapath/top level
// With MUL_MEM_READBACK_CHECK_EN defined, adds mul_result, ram_rd_data
// (DW bits each) and the chk_err flag.
interface mul_mem_seq_ctrl_if #(
  parameter int AW  = 3,
  parameter int RAW = 3,
  parameter int CW  = 4
`ifdef MUL_MEM_READBACK_CHECK_EN
  , parameter int DW = 8
`endif
);
  logic           start;
  logic [AW-1:0]  adr1;
  logic [AW-1:0]  adr2;
  logic [RAW-1:0] dst_adr;
  logic [CW-1:0]  op_count;
  logic           w_rf;
  logic [AW-1:0]  adr;
  logic           DA;
  logic           SA;
  logic           SB;
  logic           w_ram_en;
  logic           r_ram_en;
  logic [RAW-1:0] w_ram_addr;
  logic [2:0]     st_out;
  logic           busy;
  logic           done;
`ifdef MUL_MEM_READBACK_CHECK_EN
  logic [DW-1:0]  mul_result;
  logic [DW-1:0]  ram_rd_data;
  logic           chk_err;
`endif

  modport master (
    input  start, adr1, adr2, dst_adr, op_count,
`ifdef MUL_MEM_READBACK_CHECK_EN
    input  mul_result, ram_rd_data,
    output chk_err,
`endif
    output w_rf, adr, DA, SA, SB, w_ram_en, r_ram_en, w_ram_addr,
    output st_out, busy, done
  );

  modport slave (
    output start, adr1, adr2, dst_adr, op_count,
`ifdef MUL_MEM_READBACK_CHECK_EN
    output mul_result, ram_rd_data,
    input  chk_err,
`endif
    input  w_rf, adr, DA, SA, SB, w_ram_en, r_ram_en, w_ram_addr,
    input  st_out, busy, done
  );

endinterface

// File: rtl/mul_mem_seq_ctrl_mul_lat_counter.sv
// mul_lat_counter: loadable down-counter with zero flag, used to time the
// multiplier wait.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one
//   zero       : count equals zero
module mul_lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mul_mem_seq_ctrl.sv
// mul_mem_seq_ctrl: sequences a batch of op_count multiply operations
// (load A, load B, wait MUL_LAT cycles, write product to RAM, read it back),
// auto-incrementing register-file and RAM addresses with wrap-around.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mul_mem_seq_ctrl_if.master (start/adr1/adr2/dst_adr/op_count in;
//                w_rf/adr/DA/SA/SB/w_ram_en/r_ram_en/w_ram_addr/st_out/busy/done out)
// All outputs are a registered decode of the state, one cycle behind it.
// Optional macro MUL_MEM_READBACK_CHECK_EN adds parameter DW and the sticky
// readback comparison flag chk_err.
module mul_mem_seq_ctrl
  import mul_mem_pkg::*;
#(
  parameter int AW      = 3,
  parameter int RAW     = 3,
  parameter int CW      = 4,
  parameter int MUL_LAT = 1
`ifdef MUL_MEM_READBACK_CHECK_EN
  , parameter int DW    = 8
`endif
) (
  input logic               clk,
  input logic               rst_n,
  mul_mem_seq_ctrl_if.master bus
);
  localparam int LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t         state, state_nx;
  logic [AW-1:0]  cur_a, cur_b;
  logic [RAW-1:0] cur_dst;
  logic [CW-1:0]  rem;
  logic           lat_load, lat_dec, lat_zero;
  logic           accept;
  logic           last_op;
  ctrl_t          ctrl;

  assign accept  = (state == IDLE) && bus.start;
  assign last_op = (rem == CW'(1));
  assign ctrl    = ctrl_decode(state);

  mul_lat_counter #(.W(LW)) u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (LW'(MUL_LAT - 1)),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_nx = state;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nx = (bus.op_count == '0) ? DONE : LOAD_A;
      LOAD_A: state_nx = LOAD_B;
      LOAD_B: begin
        state_nx = MUL;
        lat_load = 1'b1;
      end
      MUL: begin
        if (lat_zero) state_nx = WRITE;
        else          lat_dec  = 1'b1;
      end
      WRITE:  state_nx = READ;
      READ:   state_nx = last_op ? DONE : LOAD_A;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_a   <= '0;
      cur_b   <= '0;
      cur_dst <= '0;
      rem     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cur_a   <= bus.adr1;
        cur_b   <= bus.adr2;
        cur_dst <= bus.dst_adr;
        rem     <= bus.op_count;
      end else if (state == READ) begin
        rem <= rem - CW'(1);
        if (!last_op) begin
          cur_a   <= cur_a + AW'(1);
          cur_b   <= cur_b + AW'(1);
          cur_dst <= cur_dst + RAW'(1);
        end
      end
    end
  end

  // Registered output decode of the current state.
  logic           w_rf_q, da_q, sa_q, sb_q, w_ram_en_q, r_ram_en_q, busy_q, done_q;
  logic [AW-1:0]  adr_q;
  logic [RAW-1:0] ram_addr_q;
  logic [2:0]     st_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_rf_q     <= 1'b0;
      adr_q      <= '0;
      da_q       <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      w_ram_en_q <= 1'b0;
      r_ram_en_q <= 1'b0;
      ram_addr_q <= '0;
      st_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      w_rf_q     <= (state == LOAD_A) || (state == LOAD_B);
      adr_q      <= (state == LOAD_A) ? cur_a :
                    (state == LOAD_B) ? cur_b : '0;
      da_q       <= ctrl.da;
      sa_q       <= ctrl.sa;
      sb_q       <= ctrl.sb;
      w_ram_en_q <= (state == WRITE);
      r_ram_en_q <= (state == READ);
      ram_addr_q <= ((state == WRITE) || (state == READ)) ? cur_dst : '0;
      st_q       <= state;
      busy_q     <= (state != IDLE) && (state != DONE);
      done_q     <= (state == DONE);
    end
  end

  assign bus.w_rf       = w_rf_q;
  assign bus.adr        = adr_q;
  assign bus.DA         = da_q;
  assign bus.SA         = sa_q;
  assign bus.SB         = sb_q;
  assign bus.w_ram_en   = w_ram_en_q;
  assign bus.r_ram_en   = r_ram_en_q;
  assign bus.w_ram_addr = ram_addr_q;
  assign bus.st_out     = st_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef MUL_MEM_READBACK_CHECK_EN
  logic [DW-1:0] cap;
  logic          chk_err_q;

  // Read data is compared while r_ram_en is on the pins, i.e. the cycle
  // after the READ state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap       <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (state == WRITE) cap <= bus.mul_result;
      if (accept)
        chk_err_q <= 1'b0;
      else if (r_ram_en_q && (bus.ram_rd_data != cap))
        chk_err_q <= 1'b1;
    end
  end

  assign bus.chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_mul_mem_seq_ctrl.sv
// Self-checking bench for mul_mem_seq_ctrl. Two instances (MUL_LAT=1 and
// MUL_LAT=4) receive identical stimulus; each is compared cycle by cycle
// against an expected output schedule built from the operation sequence.
module tb_mul_mem_seq_ctrl;

  typedef struct packed {
    logic       w_rf;
    logic [2:0] adr;
    logic       da;
    logic       sa;
    logic       sb;
    logic       w_en;
    logic       r_en;
    logic [2:0] waddr;
    logic [2:0] st;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] adr1 = '0, adr2 = '0, dst = '0;
  logic [3:0] opc = '0;
  int errors = 0;
  int checks = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t o1, o4;

  always #5 clk = ~clk;

  mul_mem_seq_ctrl_if #(.AW(3), .RAW(3), .CW(4)) if1 ();
  mul_mem_seq_ctrl_if #(.AW(3), .RAW(3), .CW(4)) if4 ();

  assign if1.start = start;    assign if4.start = start;
  assign if1.adr1 = adr1;      assign if4.adr1 = adr1;
  assign if1.adr2 = adr2;      assign if4.adr2 = adr2;
  assign if1.dst_adr = dst;    assign if4.dst_adr = dst;
  assign if1.op_count = opc;   assign if4.op_count = opc;

`ifdef MUL_MEM_READBACK_CHECK_EN
  logic [7:0] mul_res = '0, rd_data = '0;
  assign if1.mul_result = mul_res;  assign if4.mul_result = mul_res;
  assign if1.ram_rd_data = rd_data; assign if4.ram_rd_data = rd_data;
`endif

  mul_mem_seq_ctrl #(.AW(3), .RAW(3), .CW(4), .MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  mul_mem_seq_ctrl #(.AW(3), .RAW(3), .CW(4), .MUL_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.master));

  assign o1 = {if1.w_rf, if1.adr, if1.DA, if1.SA, if1.SB, if1.w_ram_en,
               if1.r_ram_en, if1.w_ram_addr, if1.st_out, if1.busy, if1.done};
  assign o4 = {if4.w_rf, if4.adr, if4.DA, if4.SA, if4.SB, if4.w_ram_en,
               if4.r_ram_en, if4.w_ram_addr, if4.st_out, if4.busy, if4.done};

  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pin trace starting at the first sample after the start edge:
  // one idle cycle (outputs lag the state), then per op LOAD_A, LOAD_B,
  // lat x MUL, WRITE, READ; then DONE and trailing idle cycles.
  task automatic build(input int lat, input bit sel, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input int n);
    exp_t s[$];
    exp_t e;
    s.push_back('0);
    for (int i = 0; i < n; i++) begin
      e = '0; e.busy = 1; e.st = 3'd1; e.w_rf = 1; e.adr = 3'(a + i); e.sb = 1;
      s.push_back(e);
      e = '0; e.busy = 1; e.st = 3'd2; e.w_rf = 1; e.adr = 3'(b + i); e.da = 1; e.sa = 1;
      s.push_back(e);
      for (int k = 0; k < lat; k++) begin
        e = '0; e.busy = 1; e.st = 3'd3; e.sa = 1;
        s.push_back(e);
      end
      e = '0; e.busy = 1; e.st = 3'd4; e.sa = 1; e.w_en = 1; e.waddr = 3'(d + i);
      s.push_back(e);
      e = '0; e.busy = 1; e.st = 3'd5; e.sa = 1; e.r_en = 1; e.waddr = 3'(d + i);
      s.push_back(e);
    end
    e = '0; e.st = 3'd6; e.done = 1;
    s.push_back(e);
    s.push_back('0);
    s.push_back('0);
    if (sel) q4 = s; else q1 = s;
  endtask

  // Starts a batch, then scrambles the operand inputs every cycle.
  // pulse_at: sample index at which a (to be ignored) start is re-issued.
  // abort_at: sample index after which rst_n is held low for 3 edges.
  task automatic run_batch(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic [3:0] n,
                           input int pulse_at, input int abort_at);
    int rst_left = 0;
    build(1, 1'b0, a, b, d, int'(n));
    build(4, 1'b1, a, b, d, int'(n));
    @(negedge clk);
    adr1 = a; adr2 = b; dst = d; opc = n; start = 1'b1;
    for (int c = 0; c < 300 && (q1.size() != 0 || q4.size() != 0); c++) begin
      @(negedge clk);
      if (q1.size() != 0) chk($sformatf("%s/L1/c%0d", tag, c), o1, q1.pop_front());
      if (q4.size() != 0) chk($sformatf("%s/L4/c%0d", tag, c), o4, q4.pop_front());
      adr1 = 3'($urandom); adr2 = 3'($urandom); dst = 3'($urandom);
      opc = 4'($urandom_range(1, 15));
      start = (c == pulse_at);
      if (c == abort_at) begin
        rst_n = 1'b0; rst_left = 3;
        q1.delete(); q4.delete();
        repeat (8) begin q1.push_back('0); q4.push_back('0); end
      end else if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst_n = 1'b1;
      end
    end
    checks++;
    assert (q1.size() == 0 && q4.size() == 0) else begin
      errors++;
      $error("FAIL %s/timeout observed=%0d,%0d expected=0,0 pending", tag, q1.size(), q4.size());
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/L1", o1, '0);
    chk("reset/L4", o4, '0);
    rst_n = 1'b1;

    run_batch("single", 3'd2, 3'd5, 3'd3, 4'd1, -1, -1);
    run_batch("wrap", 3'd6, 3'd7, 3'd7, 4'd3, -1, -1);
    run_batch("zero", 3'd4, 3'd1, 3'd2, 4'd0, -1, -1);
    run_batch("busy_start", 3'd1, 3'd2, 3'd4, 4'd2, 3, -1);
    for (int r = 0; r < 6; r++)
      run_batch($sformatf("rand%0d", r), 3'($urandom), 3'($urandom), 3'($urandom),
                4'($urandom_range(0, 5)), -1, -1);
    run_batch("reset_mid_mul", 3'd3, 3'd0, 3'd5, 4'd2, -1, 4);
    run_batch("after_reset", 3'd7, 3'd3, 3'd6, 4'd2, -1, -1);

`ifdef MUL_MEM_READBACK_CHECK_EN
    checks++;
    assert (if1.chk_err === 1'b0 && if4.chk_err === 1'b0) else begin
      errors++;
      $error("FAIL chk_clean observed=%b%b expected=00", if1.chk_err, if4.chk_err);
    end
    mul_res = 8'h2A; rd_data = 8'h2B;
    run_batch("chk_mismatch", 3'd2, 3'd5, 3'd3, 4'd1, -1, -1);
    repeat (3) @(negedge clk);
    checks++;
    assert (if1.chk_err === 1'b1 && if4.chk_err === 1'b1) else begin
      errors++;
      $error("FAIL chk_sticky observed=%b%b expected=11", if1.chk_err, if4.chk_err);
    end
    run_batch("chk_clear", 3'd0, 3'd0, 3'd0, 4'd0, -1, -1);
    checks++;
    assert (if1.chk_err === 1'b0 && if4.chk_err === 1'b0) else begin
      errors++;
      $error("FAIL chk_clear observed=%b%b expected=00", if1.chk_err, if4.chk_err);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
